io_out_fmt_seq: RTL and testbench
=================================

Name: io_out_fmt_seq

Overview:
Parametrised slow-output format sequencer, successor to the fixed 3-bit OF output-format shift logic in the G-15 I/O section.
- Holds a programmable store of up to FMT_DEPTH format codes.
- Walks the codes against a serial data stream, assembling CHAR_W-bit digits, sign characters and CR/TAB characters.
- Presents each character to the typewriter/punch adapter over a valid/ready handshake.
- Handles STOP, RELOAD and WAIT codes, including STOP-to-RELOAD conversion when the remaining word is nonzero.

Parameters:
FMT_DEPTH, 8, number of format-code entries in the store (≥2)
CHAR_W, 4, bits per digit character (1 = single-bit precession, 4 = normal)
CNT_W, $clog2(FMT_DEPTH+1), width of the fill count (derived)

Ports:
CLOCK      in   1          system clock
rst        in   1          asynchronous reset, active-high
fmt_clr    in   1          empty format store (ignored while busy)
fmt_wr     in   1          append fmt_code (ignored while busy or full)
fmt_code   in   3          format code: 000 DIGIT, 001 SIGN, x10 CR_TAB, 100 STOP, 101 RELOAD, 111 WAIT
fmt_count  out  CNT_W      entries stored
fmt_full   out  1          fmt_count == FMT_DEPTH
start      in   1          begin line (ignored while busy)
abort      in   1          terminate sequence
bit_en     in   1          one-cycle bit-time strobe
data_bit   in   1          serial data, LSB first, sampled on bit_en
data_nz    in   1          remaining word nonzero (sampled at STOP)
ch_valid   out  1          character available
ch_kind    out  3          format code of the emitted character
ch_data    out  CHAR_W     character bits
ch_ready   in   1          adapter accepts character
reload     out  1          one-cycle pulse on RELOAD (real or converted)
busy       out  1          FSM not IDLE
done       out  1          one-cycle pulse at normal end of line

Behaviour:
- Reset values (async): FSM=IDLE, idx=0, fmt_count=0, ch_valid=0, ch_kind=0, ch_data=0, reload=0, done=0, busy=0. Store contents are don't-care.
- Store writes:
  - fmt_wr writes entry[fmt_count] and increments the count.
  - fmt_clr has priority over fmt_wr in the same cycle.
  - Both are ignored while busy.
  - fmt_wr while full is a no-op.
- States: IDLE, FETCH, SHIFT, EMIT.
- IDLE:
  - start with fmt_count>0 → FETCH with idx=0.
  - start with fmt_count==0 → done pulse, remain IDLE.
- FETCH (one cycle): evaluate entry[idx]. If idx==fmt_count, the entry is treated as STOP.
  - DIGIT or WAIT: bit counter = CHAR_W, sreg cleared, → SHIFT.
  - SIGN: bit counter = 1 → SHIFT.
  - CR_TAB: ch_data = 0 → EMIT.
  - STOP with data_nz=0: done pulse → IDLE.
  - STOP with data_nz=1: behaves as RELOAD.
  - RELOAD: reload pulse, idx ← 0, → FETCH.
- SHIFT:
  - Each bit_en does sreg ← {data_bit, sreg[CHAR_W-1:1]} and decrements the counter.
  - For SIGN, the bit lands in ch_data[0] and the upper bits are 0.
  - When the counter reaches 0: WAIT → FETCH with idx+1, no character emitted; otherwise → EMIT.
  - Cycles without bit_en hold state.
- EMIT:
  - ch_valid=1. ch_kind and ch_data stay stable until ch_valid & ch_ready.
  - On the handshake: ch_valid falls next cycle, idx+1, → FETCH.
  - ch_ready while ch_valid=0 is ignored.
- Latency: the last bit_en of a character produces ch_valid on the following clock.
- abort, from any state, has priority over every transition:
  - Next cycle: IDLE, ch_valid=0, idx=0.
  - No done, no reload.
  - Store is preserved.
- Simultaneous events:
  - start and abort together → abort wins.
  - bit_en in FETCH or EMIT is ignored; data bits there are lost by design.
- Reset mid-operation clears everything, including the store count.

Test Plan:
1. Store {DIGIT,STOP}, CHAR_W=4, start, bits 1,0,1,1 on four bit_en → ch_valid, ch_kind=000, ch_data=4'b1101; after ch_ready, data_nz=0 → done pulse, busy=0.
2. Store {SIGN,CR_TAB,STOP}, bit 1 → characters (001,4'b0001) then (010,4'b0000); ch_ready held low 5 cycles → ch_valid/ch_data stable throughout.
3. Store {DIGIT,STOP}, data_nz=1 at STOP → reload pulse, idx restarts, second digit emitted; then data_nz=0 → done.
4. Store {WAIT,DIGIT,RELOAD}, 8 bits 0xA5 LSB first → only one character emitted, ch_data=4'hA; reload pulse after it.
5. Fill 8 entries plus a 9th fmt_wr → fmt_count=8, fmt_full=1; fmt_wr while busy is ignored; fmt_clr with fmt_wr → count 0.
6. abort during SHIFT and during EMIT, and rst asserted mid-EMIT → IDLE next cycle, ch_valid=0, no done; after abort the store is intact and a fresh start reproduces scenario 1.

Source files
------------

// File: rtl/io_out_fmt_seq.sv
// Slow-output format sequencer: walks a programmable store of format codes
// against a serial data stream and hands characters to the output adapter.
module io_out_fmt_seq #(
    parameter int unsigned FMT_DEPTH = 8,
    parameter int unsigned CHAR_W    = 4,
    parameter int unsigned CNT_W     = $clog2(FMT_DEPTH + 1)
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              fmt_clr,
    input  logic              fmt_wr,
    input  logic [2:0]        fmt_code,
    output logic [CNT_W-1:0]  fmt_count,
    output logic              fmt_full,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_en,
    input  logic              data_bit,
    input  logic              data_nz,
    output logic              ch_valid,
    output logic [2:0]        ch_kind,
    output logic [CHAR_W-1:0] ch_data,
    input  logic              ch_ready,
    output logic              reload,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W  = $clog2(FMT_DEPTH);
    localparam int unsigned BCNT_W = $clog2(CHAR_W + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FMT_DEPTH);

    localparam logic [2:0] C_DIGIT  = 3'b000;
    localparam logic [2:0] C_SIGN   = 3'b001;
    localparam logic [2:0] C_CR     = 3'b010;
    localparam logic [2:0] C_TAB    = 3'b110;
    localparam logic [2:0] C_STOP   = 3'b100;
    localparam logic [2:0] C_RELOAD = 3'b101;
    localparam logic [2:0] C_WAIT   = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, EMIT} state_t;

    state_t              state;
    logic [2:0]          store [FMT_DEPTH];
    logic [CNT_W-1:0]    idx;
    logic [BCNT_W-1:0]   bcnt;
    logic [CHAR_W-1:0]   sreg;
    logic [CHAR_W-1:0]   sreg_sh;
    logic [CHAR_W-1:0]   sign_ch;
    logic [2:0]          cur_code;
    logic [2:0]          fetch_code;
    logic                store_we;

    assign busy     = (state != IDLE);
    assign fmt_full = (fmt_count == DEPTH_C);
    assign store_we = fmt_wr && !fmt_clr && !busy && !fmt_full;

    always_ff @(posedge CLOCK) begin
        if (store_we)
            store[fmt_count[IDX_W-1:0]] <= fmt_code;
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)
            fmt_count <= '0;
        else if (!busy) begin
            if (fmt_clr)
                fmt_count <= '0;
            else if (fmt_wr && !fmt_full)
                fmt_count <= fmt_count + 1'b1;
        end
    end

    // Reading past the last stored entry behaves as an implicit STOP.
    always_comb begin
        fetch_code = C_STOP;
        if (idx < fmt_count)
            fetch_code = store[idx[IDX_W-1:0]];
        sreg_sh    = CHAR_W'({data_bit, sreg} >> 1);
        sign_ch    = '0;
        sign_ch[0] = data_bit;
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            bcnt     <= '0;
            sreg     <= '0;
            cur_code <= '0;
            ch_valid <= 1'b0;
            ch_kind  <= '0;
            ch_data  <= '0;
            reload   <= 1'b0;
            done     <= 1'b0;
        end else begin
            reload <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                ch_valid <= 1'b0;
                idx      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (fmt_count != '0) begin
                                state <= FETCH;
                                idx   <= '0;
                            end else
                                done <= 1'b1;
                        end
                    end
                    FETCH: begin
                        cur_code <= fetch_code;
                        case (fetch_code)
                            C_DIGIT, C_WAIT: begin
                                bcnt  <= BCNT_W'(CHAR_W);
                                sreg  <= '0;
                                state <= SHIFT;
                            end
                            C_SIGN: begin
                                bcnt  <= BCNT_W'(1);
                                sreg  <= '0;
                                state <= SHIFT;
                            end
                            C_CR, C_TAB: begin
                                ch_kind  <= fetch_code;
                                ch_data  <= '0;
                                ch_valid <= 1'b1;
                                state    <= EMIT;
                            end
                            C_RELOAD: begin
                                reload <= 1'b1;
                                idx    <= '0;
                            end
                            default: begin
                                // STOP with a nonzero remainder restarts the line instead.
                                if (data_nz) begin
                                    reload <= 1'b1;
                                    idx    <= '0;
                                end else begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end
                            end
                        endcase
                    end
                    SHIFT: begin
                        if (bit_en) begin
                            sreg <= sreg_sh;
                            bcnt <= bcnt - 1'b1;
                            if (bcnt == BCNT_W'(1)) begin
                                if (cur_code == C_WAIT) begin
                                    idx   <= idx + 1'b1;
                                    state <= FETCH;
                                end else begin
                                    ch_kind  <= cur_code;
                                    ch_data  <= (cur_code == C_SIGN) ? sign_ch : sreg_sh;
                                    ch_valid <= 1'b1;
                                    state    <= EMIT;
                                end
                            end
                        end
                    end
                    EMIT: begin
                        if (ch_ready) begin
                            ch_valid <= 1'b0;
                            idx      <= idx + 1'b1;
                            state    <= FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_out_fmt_seq.sv
// Directed bench for io_out_fmt_seq; emitted characters are checked against a
// queue of hand-computed expectations by a negedge monitor.
module tb_io_out_fmt_seq;

    localparam int unsigned FMT_DEPTH = 8;
    localparam int unsigned CHAR_W    = 4;
    localparam int unsigned CNT_W     = 4;

    logic              CLOCK = 1'b0;
    logic              rst = 1'b1;
    logic              fmt_clr = 1'b0;
    logic              fmt_wr = 1'b0;
    logic [2:0]        fmt_code = '0;
    logic [CNT_W-1:0]  fmt_count;
    logic              fmt_full;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              bit_en = 1'b0;
    logic              data_bit = 1'b0;
    logic              data_nz = 1'b0;
    logic              ch_valid;
    logic [2:0]        ch_kind;
    logic [CHAR_W-1:0] ch_data;
    logic              ch_ready = 1'b1;
    logic              reload;
    logic              busy;
    logic              done;

    io_out_fmt_seq #(.FMT_DEPTH(FMT_DEPTH), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .rst(rst), .fmt_clr(fmt_clr), .fmt_wr(fmt_wr),
        .fmt_code(fmt_code), .fmt_count(fmt_count), .fmt_full(fmt_full),
        .start(start), .abort(abort), .bit_en(bit_en), .data_bit(data_bit),
        .data_nz(data_nz), .ch_valid(ch_valid), .ch_kind(ch_kind),
        .ch_data(ch_data), .ch_ready(ch_ready), .reload(reload),
        .busy(busy), .done(done)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int reload_cnt = 0;
    int d0, r0;
    logic [6:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge CLOCK) begin : monitor
        logic [6:0] e;
        if (done) done_cnt++;
        if (reload) reload_cnt++;
        if (!rst && ch_valid && ch_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL char_unexpected: got kind=%0h data=%0h required none", ch_kind, ch_data);
            end else begin
                e = exp_q.pop_front();
                chk("char_kind", 32'(ch_kind), 32'(e[6:4]));
                chk("char_data", 32'(ch_data), 32'(e[3:0]));
            end
        end
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wr(input logic [2:0] c);
        fmt_code = c;
        fmt_wr = 1'b1;
        tick();
        fmt_wr = 1'b0;
    endtask

    task automatic clr;
        fmt_clr = 1'b1;
        tick();
        fmt_clr = 1'b0;
    endtask

    // start edge enters FETCH, the following edge leaves it
    task automatic go;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        data_bit = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        tick();
    endtask

    task automatic send_nib(input logic [3:0] v);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ch_valid), 0);
        chk("rst_kind", 32'(ch_kind), 0);
        chk("rst_data", 32'(ch_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_reload", 32'(reload), 0);
        chk("rst_count", 32'(fmt_count), 0);
        chk("rst_full", 32'(fmt_full), 0);

        // 1: single digit then STOP
        clr();
        wr(3'b000);
        wr(3'b100);
        chk("s1_count", 32'(fmt_count), 2);
        data_nz = 1'b0;
        d0 = done_cnt; r0 = reload_cnt;
        exp_q.push_back({3'b000, 4'b1101});
        go();
        send_nib(4'b1101);
        wait_idle("s1_idle");
        tick();
        chk("s1_done", 32'(done_cnt - d0), 1);
        chk("s1_reload", 32'(reload_cnt - r0), 0);

        // 2: SIGN, CR_TAB, STOP with back-pressure
        clr();
        wr(3'b001);
        wr(3'b010);
        wr(3'b100);
        ch_ready = 1'b0;
        d0 = done_cnt;
        exp_q.push_back({3'b001, 4'b0001});
        exp_q.push_back({3'b010, 4'b0000});
        go();
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("s2_hold_valid", 32'(ch_valid), 1);
            chk("s2_hold_kind", 32'(ch_kind), 32'b001);
            chk("s2_hold_data", 32'(ch_data), 32'b0001);
            tick();
        end
        ch_ready = 1'b1;
        wait_idle("s2_idle");
        tick();
        chk("s2_done", 32'(done_cnt - d0), 1);
        chk("s2_queue", 32'(exp_q.size()), 0);

        // 3: STOP with nonzero remainder converts to RELOAD
        clr();
        wr(3'b000);
        wr(3'b100);
        data_nz = 1'b1;
        d0 = done_cnt; r0 = reload_cnt;
        exp_q.push_back({3'b000, 4'h6});
        exp_q.push_back({3'b000, 4'h9});
        go();
        send_nib(4'h6);
        tick();
        data_nz = 1'b0;
        tick();
        send_nib(4'h9);
        wait_idle("s3_idle");
        tick();
        chk("s3_reload", 32'(reload_cnt - r0), 1);
        chk("s3_done", 32'(done_cnt - d0), 1);

        // 4: WAIT swallows the low nibble of 0xA5
        clr();
        wr(3'b111);
        wr(3'b000);
        wr(3'b101);
        d0 = done_cnt; r0 = reload_cnt;
        exp_q.push_back({3'b000, 4'hA});
        go();
        send_nib(4'h5);
        send_nib(4'hA);
        for (int i = 0; i < 4; i++) tick();
        chk("s4_reload", 32'(reload_cnt - r0), 1);
        chk("s4_busy", 32'(busy), 1);
        chk("s4_queue", 32'(exp_q.size()), 0);
        do_abort();
        chk("s4_abort_busy", 32'(busy), 0);
        tick();
        chk("s4_done", 32'(done_cnt - d0), 0);

        // start and abort together
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);

        // 5: store fill, full, writes while busy, clr priority
        clr();
        for (int i = 0; i < 8; i++) wr(3'b111);
        chk("s5_count8", 32'(fmt_count), 8);
        chk("s5_full", 32'(fmt_full), 1);
        wr(3'b000);
        chk("s5_count9", 32'(fmt_count), 8);
        go();
        wr(3'b000);
        chk("s5_wr_busy", 32'(fmt_count), 8);
        clr();
        chk("s5_clr_busy", 32'(fmt_count), 8);
        do_abort();
        chk("s5_abort_busy", 32'(busy), 0);
        fmt_clr = 1'b1;
        fmt_wr = 1'b1;
        tick();
        fmt_clr = 1'b0;
        fmt_wr = 1'b0;
        chk("s5_clr_wr", 32'(fmt_count), 0);
        chk("s5_not_full", 32'(fmt_full), 0);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("s5_empty_done", 32'(done_cnt - d0), 1);
        chk("s5_empty_busy", 32'(busy), 0);

        // 6: abort in SHIFT and EMIT, then reset mid-EMIT
        clr();
        wr(3'b000);
        wr(3'b100);
        d0 = done_cnt; r0 = reload_cnt;
        go();
        send_bit(1'b1);
        send_bit(1'b0);
        do_abort();
        chk("s6_shift_busy", 32'(busy), 0);
        chk("s6_shift_valid", 32'(ch_valid), 0);
        ch_ready = 1'b0;
        go();
        send_nib(4'hD);
        chk("s6_emit_valid", 32'(ch_valid), 1);
        do_abort();
        chk("s6_abort_valid", 32'(ch_valid), 0);
        chk("s6_abort_busy", 32'(busy), 0);
        tick();
        chk("s6_no_done", 32'(done_cnt - d0), 0);
        chk("s6_no_reload", 32'(reload_cnt - r0), 0);
        chk("s6_store_kept", 32'(fmt_count), 2);
        ch_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back({3'b000, 4'b1101});
        go();
        send_nib(4'b1101);
        wait_idle("s6_rerun_idle");
        tick();
        chk("s6_rerun_done", 32'(done_cnt - d0), 1);
        ch_ready = 1'b0;
        go();
        send_nib(4'h3);
        chk("s6_pre_rst_valid", 32'(ch_valid), 1);
        rst = 1'b1;
        #1;
        chk("s6_rst_valid", 32'(ch_valid), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_count", 32'(fmt_count), 0);
        tick();
        rst = 1'b0;
        ch_ready = 1'b1;
        tick();

        chk("final_queue", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
